store_byte_serializer: RTL and testbench
========================================

# store_byte_serializer

Store-side companion to the datapath's immediate/load sign extension. It narrows a 32-bit register value to the byte, halfword or word selected by the store instruction and writes it into the byte-wide data memory one byte per cycle. It sits between the MEM-stage store request and the data-memory write port, with a valid/ready handshake on the request side and a write/ack handshake on the memory side.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- BIG_ENDIAN, 1, 1 = MIPS big-endian byte order; 0 = little-endian.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  store request present.
- REQ_READY  out  1  block can accept a request; high only in IDLE.
- REQ_ADDR  in  ADDR_W  byte address of the store.
- REQ_DATA  in  32  register value; only the low 8, 16 or 32 bits are stored.
- REQ_SIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- MEM_WE  out  1  byte write request to memory.
- MEM_ADDR  out  ADDR_W  byte address of the current write.
- MEM_WDATA  out  8  byte being written.
- MEM_ACK  in  1  memory accepts the byte when MEM_WE && MEM_ACK.
- DONE  out  1  one-cycle pulse: store completed.
- ALIGN_ERR  out  1  one-cycle pulse: request rejected.

## Operation
- States: IDLE, WRITE.
- Accept: REQ_VALID && REQ_READY on a rising edge.
- Legality check at accept:
  - half needs REQ_ADDR[0] = 0;
  - word needs REQ_ADDR[1:0] = 00;
  - size 11 is always illegal.
- Illegal request: stay in IDLE, no MEM_WE. ALIGN_ERR = 1 for the following cycle.
- Legal request:
  - latch address, data and byte count (1, 2 or 4); go to WRITE.
- Byte order: writes are always issued in ascending address order, starting at REQ_ADDR.
  - BIG_ENDIAN = 1: the first byte is the most significant byte of the stored quantity. Half stores REQ_DATA[15:8] then [7:0]; word stores [31:24], [23:16], [15:8], [7:0].
  - BIG_ENDIAN = 0: least significant byte first.
- WRITE:
  - MEM_WE = 1, with MEM_ADDR and MEM_WDATA held stable until MEM_ACK.
  - On ack: advance the address by 1 (mod 2^ADDR_W), select the next byte and decrement the count.
  - On ack of the last byte: go to IDLE; DONE = 1 for the following cycle.
- In the DONE and ALIGN_ERR pulse cycles the state is already IDLE. REQ_READY = 1, so a new request may be accepted back-to-back.
- Reset values: state IDLE, REQ_READY = 1, MEM_WE = 0, MEM_ADDR = 0, MEM_WDATA = 0, DONE = 0, ALIGN_ERR = 0, count = 0.
- RESET mid-store aborts the store immediately (asynchronous). Bytes already acked stay written; no DONE is produced.

## Timing
- MEM_WE, MEM_ADDR, MEM_WDATA, DONE and ALIGN_ERR are registered outputs.
- REQ_READY is decoded from the state register only; no combinational path from REQ_VALID.
- MEM_ACK must not combinationally affect any output.
- With MEM_ACK tied high, for a request accepted at edge 0:
  - MEM_WE is high in cycles 1..N (N = 1, 2 or 4);
  - DONE is high in cycle N+1;
  - total latency is N+1 cycles.
- Each cycle with MEM_WE = 1 and MEM_ACK = 0 adds one cycle, with outputs unchanged.
- An illegal request gives ALIGN_ERR in cycle 1 and no other activity.

## Structure
- Shared package mips_mem_pkg holds:
  - the size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - a state enum for IDLE/WRITE;
  - a function for byte-lane selection (data, byte index, size, endianness).
- No sub-module. The FSM, address/count registers and lane select sit in one module.

## Test plan
- Word 0x11223344 at 0x100, BIG_ENDIAN = 1, ACK tied high -> writes 0x100:11, 0x101:22, 0x102:33, 0x103:44 in cycles 1–4; DONE in cycle 5.
- Half with REQ_DATA = 0xABCD1234 at 0x202 -> 0x202:12, 0x203:34, then DONE. With BIG_ENDIAN = 0 -> 0x202:34, 0x203:12.
- Byte 0x000000EE at 0x003 -> a single write 0x003:EE; DONE in cycle 2. A second request held valid is accepted in the DONE cycle, and its first write appears the next cycle.
- Word at 0x102, half at 0x201 and size 11 at 0x000 -> no MEM_WE; ALIGN_ERR pulses once for each request; REQ_READY stays 1.
- Word at 0x100 with MEM_ACK low for 3 cycles on byte 1 -> MEM_ADDR = 0x101 and MEM_WDATA = 0x22 held for 4 cycles; DONE in cycle 8.
- RESET asserted mid-edge-cycle during byte 2 of a word -> MEM_WE drops without waiting for a clock edge; no DONE. After release, REQ_READY = 1 and a new byte store completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: store size encodings, serializer state enum and byte-lane helpers
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic {ST_IDLE, ST_WRITE} state_e;
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return size == SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : 3'd1;
  endfunction
  function automatic logic size_legal(input logic [1:0] addr_lo, input logic [1:0] size);
    return size == SZ_BYTE || (size == SZ_HALF && !addr_lo[0]) || (size == SZ_WORD && addr_lo == 2'b00);
  endfunction
  function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] idx,
                                           input logic [1:0] size, input logic big_endian);
    logic [1:0] last;
    logic [1:0] pos;
    last = size == SZ_WORD ? 2'd3 : size == SZ_HALF ? 2'd1 : 2'd0;
    pos = big_endian ? last - idx : idx;
    return data[{pos, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/store_byte_serializer.sv
// store_byte_serializer: narrows a store to byte/half/word and writes it one byte per cycle
module store_byte_serializer
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_DATA,
  input  logic [1:0]        REQ_SIZE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  input  logic              MEM_ACK,
  output logic              DONE,
  output logic              ALIGN_ERR
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0] size_q, size_d, idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wdata_q, wdata_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    wdata_d = wdata_q;
    we_d = we_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (REQ_VALID && size_legal(REQ_ADDR[1:0], REQ_SIZE)) begin
        state_d = ST_WRITE;
        addr_d = REQ_ADDR;
        data_d = REQ_DATA;
        size_d = REQ_SIZE;
        idx_d = 2'd0;
        cnt_d = size_bytes(REQ_SIZE);
        wdata_d = lane_byte(REQ_DATA, 2'd0, REQ_SIZE, BIG_ENDIAN);
        we_d = 1'b1;
      end else if (REQ_VALID) begin
        err_d = 1'b1;
      end
    end else if (MEM_ACK) begin
      addr_d = addr_q + ADDR_W'(1);
      idx_d = idx_q + 2'd1;
      cnt_d = cnt_q - 3'd1;
      wdata_d = lane_byte(data_q, idx_q + 2'd1, size_q, BIG_ENDIAN);
      if (cnt_q == 3'd1) begin
        state_d = ST_IDLE;
        we_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end
  assign REQ_READY = state_q == ST_IDLE;
  assign MEM_WE = we_q;
  assign MEM_ADDR = addr_q;
  assign MEM_WDATA = wdata_q;
  assign DONE = done_q;
  assign ALIGN_ERR = err_q;
endmodule

// File: tb/tb_store_byte_serializer.sv
// tb_store_byte_serializer: directed table and sequence checks of big- and little-endian instances
module tb_store_byte_serializer;
  logic clk, rst, req_valid, mem_ack;
  logic [31:0] req_addr, req_data;
  logic [1:0] req_size;
  logic ready_b, we_b, done_b, err_b, ready_l, we_l, done_l, err_l;
  logic [31:0] addr_b, addr_l;
  logic [7:0] wdata_b, wdata_l;
  int checks = 0;
  int errors = 0;
  store_byte_serializer #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_b (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(ready_b), .REQ_ADDR(req_addr),
    .REQ_DATA(req_data), .REQ_SIZE(req_size), .MEM_WE(we_b), .MEM_ADDR(addr_b),
    .MEM_WDATA(wdata_b), .MEM_ACK(mem_ack), .DONE(done_b), .ALIGN_ERR(err_b));
  store_byte_serializer #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_l (
    .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_READY(ready_l), .REQ_ADDR(req_addr),
    .REQ_DATA(req_data), .REQ_SIZE(req_size), .MEM_WE(we_l), .MEM_ADDR(addr_l),
    .MEM_WDATA(wdata_l), .MEM_ACK(mem_ack), .DONE(done_l), .ALIGN_ERR(err_l));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] data;
    int n;
    logic [31:0] be_b;
    logic [31:0] le_b;
  } vec_t;
  vec_t vecs[7];
  logic [31:0] st_addr[7];
  logic [7:0] st_data[7];
  logic st_ack[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_size = v.size;
    req_addr = v.addr;
    req_data = v.data;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.n == 0) begin
      chk("align_err_be", err_b, 1);
      chk("align_err_le", err_l, 1);
      chk("no_we_on_err", we_b, 0);
      chk("ready_on_err", ready_b, 1);
      @(negedge clk);
      chk("align_err_single", err_b, 0);
      chk("no_we_after_err", we_b, 0);
    end else begin
      for (int i = 0; i < v.n; i++) begin
        if (i > 0) @(negedge clk);
        chk("we_be", we_b, 1);
        chk("addr_be", addr_b, v.addr + i);
        chk("wdata_be", wdata_b, v.be_b[(31 - 8 * i) -: 8]);
        chk("we_le", we_l, 1);
        chk("addr_le", addr_l, v.addr + i);
        chk("wdata_le", wdata_l, v.le_b[(31 - 8 * i) -: 8]);
        chk("ready_busy", ready_b, 0);
        chk("done_early", done_b, 0);
      end
      @(negedge clk);
      chk("done_be", done_b, 1);
      chk("done_le", done_l, 1);
      chk("we_off_done", we_b, 0);
      chk("ready_done", ready_b, 1);
    end
  endtask
  initial begin
    vecs[0] = '{2'b10, 32'h100, 32'h11223344, 4, 32'h11223344, 32'h44332211};
    vecs[1] = '{2'b01, 32'h202, 32'hABCD1234, 2, 32'h12340000, 32'h34120000};
    vecs[2] = '{2'b00, 32'h003, 32'h000000EE, 1, 32'hEE000000, 32'hEE000000};
    vecs[3] = '{2'b10, 32'h102, 32'h01020304, 0, 32'h0, 32'h0};
    vecs[4] = '{2'b01, 32'h201, 32'h01020304, 0, 32'h0, 32'h0};
    vecs[5] = '{2'b11, 32'h000, 32'h01020304, 0, 32'h0, 32'h0};
    vecs[6] = '{2'b01, 32'hFFFFFFFE, 32'h0000BEEF, 2, 32'hBEEF0000, 32'hEFBE0000};
    st_addr = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103};
    st_data = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
    st_ack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    mem_ack = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    #12;
    chk("rst_ready", ready_b, 1);
    chk("rst_we", we_b, 0);
    chk("rst_addr", addr_b, 0);
    chk("rst_wdata", wdata_b, 0);
    chk("rst_done", done_b, 0);
    chk("rst_err", err_b, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) run_vec(vecs[k]);
    // back-to-back: second request held valid while the first is writing
    @(negedge clk);
    req_size = 2'b00;
    req_addr = 32'h003;
    req_data = 32'h000000EE;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h010;
    req_data = 32'h00000055;
    chk("b2b_first_we", we_b, 1);
    chk("b2b_first_addr", addr_b, 32'h003);
    chk("b2b_first_data", wdata_b, 8'hEE);
    @(negedge clk);
    chk("b2b_done", done_b, 1);
    chk("b2b_ready", ready_b, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_we", we_b, 1);
    chk("b2b_second_addr", addr_b, 32'h010);
    chk("b2b_second_data", wdata_b, 8'h55);
    @(negedge clk);
    chk("b2b_second_done", done_b, 1);
    // ack stall on byte 1 of a word
    @(negedge clk);
    req_size = 2'b10;
    req_addr = 32'h100;
    req_data = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = st_ack[c];
      chk("stall_we", we_b, 1);
      chk("stall_addr", addr_b, st_addr[c]);
      chk("stall_data", wdata_b, st_data[c]);
      chk("stall_no_done", done_b, 0);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    chk("stall_done_c8", done_b, 1);
    chk("stall_we_off", we_b, 0);
    // asynchronous reset during the third byte of a word
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we", we_b, 1);
    chk("pre_rst_addr", addr_b, 32'h102);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_we", we_b, 0);
    chk("async_rst_addr", addr_b, 0);
    chk("async_rst_done", done_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready_b, 1);
    chk("post_rst_done", done_b, 0);
    chk("post_rst_we", we_b, 0);
    run_vec(vecs[2]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
